// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator.
// Produces sync, blanking, coordinates and one of four test patterns, all
// registered so every output lags the h/v counters by exactly one clock.
module vga_pattern_gen #(
    parameter int CW         = 2,
    parameter int CNTW       = 11,
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int CHK_LOG2   = 5,
    parameter int GRAD_SHIFT = 5,
    parameter int BOX        = 64,
    parameter int BOX_Y      = 256,
    parameter int BOX_STEP   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      mode,
    output logic            Hs,
    output logic            Vs,
    output logic            Blank,
    output logic [CW-1:0]   R,
    output logic [CW-1:0]   G,
    output logic [CW-1:0]   B,
    output logic            frame_start,
    output logic [CNTW-1:0] x,
    output logic [CNTW-1:0] y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int W1      = CNTW + 1;

    localparam logic [CNTW-1:0] H_LAST   = CNTW'(H_TOTAL - 1);
    localparam logic [CNTW-1:0] V_LAST   = CNTW'(V_TOTAL - 1);
    localparam logic [CNTW-1:0] H_ACT    = CNTW'(H_ACTIVE);
    localparam logic [CNTW-1:0] V_ACT    = CNTW'(V_ACTIVE);
    localparam logic [CNTW-1:0] HS_START = CNTW'(H_ACTIVE + H_FP);
    localparam logic [CNTW-1:0] HS_END   = CNTW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNTW-1:0] VS_START = CNTW'(V_ACTIVE + V_FP);
    localparam logic [CNTW-1:0] VS_END   = CNTW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0]   ONES     = {CW{1'b1}};

    // Counter and frame-state registers
    logic [CNTW-1:0] h_q, h_d;
    logic [CNTW-1:0] v_q, v_d;
    logic [CNTW-1:0] box_x_q, box_x_d;
    logic [1:0]      mode_q, mode_d;

    // Registered outputs
    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic            blank_q, blank_d;
    logic [CW-1:0]   r_q, r_d;
    logic [CW-1:0]   g_q, g_d;
    logic [CW-1:0]   b_q, b_d;
    logic            fs_q, fs_d;
    logic [CNTW-1:0] x_q, x_d;
    logic [CNTW-1:0] y_q, y_d;

    // Pattern helpers
    logic            frame_end;
    logic            active;
    logic [CNTW-1:0] bar_idx;
    logic [2:0]      bar_col;
    logic            in_box;
    logic [W1-1:0]   box_next;
    logic [CW-1:0]   pat_r, pat_g, pat_b;

    // Advance h/v, and at the last pixel of a frame latch the new mode and step the box
    always_comb begin
        h_d       = h_q + CNTW'(1);
        v_d       = v_q;
        box_x_d   = box_x_q;
        mode_d    = mode_q;
        frame_end = (h_q == H_LAST) && (v_q == V_LAST);
        box_next  = {1'b0, box_x_q} + W1'(BOX_STEP);
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CNTW'(1);
        end
        if (frame_end) begin
            mode_d  = mode;
            box_x_d = ((box_next + W1'(BOX)) > W1'(H_ACTIVE)) ? '0 : box_next[CNTW-1:0];
        end
        if (!reset_n) begin
            h_d     = '0;
            v_d     = '0;
            box_x_d = '0;
            mode_d  = mode;
        end
    end

    // Evaluate the selected pattern at the current counter position
    always_comb begin
        pat_r   = '0;
        pat_g   = '0;
        pat_b   = '0;
        bar_idx = h_q / CNTW'(BAR_W);
        bar_col = (bar_idx > CNTW'(7)) ? 3'd0 : 3'd7 - bar_idx[2:0];
        in_box  = ({1'b0, h_q} >= {1'b0, box_x_q}) &&
                  ({1'b0, h_q} <  ({1'b0, box_x_q} + W1'(BOX))) &&
                  ({1'b0, v_q} >= W1'(BOX_Y)) &&
                  ({1'b0, v_q} <  W1'(BOX_Y + BOX));
        case (mode_q)
            2'd0: begin
                pat_r = bar_col[2] ? ONES : '0;
                pat_g = bar_col[1] ? ONES : '0;
                pat_b = bar_col[0] ? ONES : '0;
            end
            2'd1: begin
                pat_r = (h_q[CHK_LOG2] ^ v_q[CHK_LOG2]) ? ONES : '0;
                pat_g = pat_r;
                pat_b = pat_r;
            end
            2'd2: begin
                pat_r = h_q[GRAD_SHIFT+CW-1:GRAD_SHIFT];
                pat_g = pat_r;
                pat_b = pat_r;
            end
            default: begin
                pat_r = in_box ? ONES : '0;
                pat_g = pat_r;
                pat_b = ONES;
            end
        endcase
    end

    // Compute next sync, blanking, colour and coordinate outputs
    always_comb begin
        active  = (h_q < H_ACT) && (v_q < V_ACT);
        hs_d    = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : !HS_POL;
        vs_d    = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : !VS_POL;
        blank_d = !active;
        r_d     = active ? pat_r : '0;
        g_d     = active ? pat_g : '0;
        b_d     = active ? pat_b : '0;
        fs_d    = (h_q == '0) && (v_q == '0);
        x_d     = h_q;
        y_d     = v_q;
        if (!reset_n) begin
            hs_d    = !HS_POL;
            vs_d    = !VS_POL;
            blank_d = 1'b1;
            r_d     = '0;
            g_d     = '0;
            b_d     = '0;
            fs_d    = 1'b0;
            x_d     = '0;
            y_d     = '0;
        end
    end

    // Register counters, frame state and all outputs
    always_ff @(posedge clk) begin
        h_q     <= h_d;
        v_q     <= v_d;
        box_x_q <= box_x_d;
        mode_q  <= mode_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        blank_q <= blank_d;
        r_q     <= r_d;
        g_q     <= g_d;
        b_q     <= b_d;
        fs_q    <= fs_d;
        x_q     <= x_d;
        y_q     <= y_d;
    end

    assign Hs          = hs_q;
    assign Vs          = vs_q;
    assign Blank       = blank_q;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;
    assign frame_start = fs_q;
    assign x           = x_q;
    assign y           = y_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen using a small timing set so several
// frames fit in a short run: 80x18 total, 64x12 active, Hs active-low.
module tb_vga_pattern_gen;

    localparam int CW   = 2;
    localparam int CNTW = 8;
    localparam int HTOT = 80;
    localparam int FRAME = 80 * 18;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic            Hs, Vs, Blank, frame_start;
    logic [CW-1:0]   R, G, B;
    logic [CNTW-1:0] x, y;

    typedef struct {
        int          epoch;
        int          p;
        string       name;
        logic        hs, vs, blank, fs;
        logic [1:0]  r, g, b;
        logic [7:0]  xx, yy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   stim_epoch = 1;
    int   n = 0;
    bit   stim_done = 1'b0;

    vga_pattern_gen #(
        .CW(CW), .CNTW(CNTW),
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b1),
        .CHK_LOG2(2), .GRAD_SHIFT(2),
        .BOX(8), .BOX_Y(4), .BOX_STEP(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .Hs(Hs), .Vs(Vs), .Blank(Blank),
        .R(R), .G(G), .B(B),
        .frame_start(frame_start), .x(x), .y(y)
    );

    // Pixel clock
    always #5 clk = ~clk;

    // Queue one expected output vector
    task automatic pushExp(input string name, input int p, input logic hs, input logic vs,
                           input logic blank, input logic fs, input logic [1:0] r,
                           input logic [1:0] g, input logic [1:0] b, input int xx, input int yy);
        exp_t e;
        e.epoch = stim_epoch; e.p = p; e.name = name;
        e.hs = hs; e.vs = vs; e.blank = blank; e.fs = fs;
        e.r = r; e.g = g; e.b = b; e.xx = 8'(xx); e.yy = 8'(yy);
        exp_q.push_back(e);
    endtask

    // Expected active-video pixel (Hs idle high, Vs idle low)
    task automatic expActive(input string name, input int f, input int h, input int v,
                             input logic fs, input logic [1:0] r, input logic [1:0] g,
                             input logic [1:0] b);
        pushExp(name, f * FRAME + v * HTOT + h, 1'b1, 1'b0, 1'b0, fs, r, g, b, h, v);
    endtask

    // Expected blanking pixel
    task automatic expBlank(input string name, input int f, input int h, input int v,
                            input logic hs, input logic vs);
        pushExp(name, f * FRAME + v * HTOT + h, hs, vs, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, h, v);
    endtask

    // Expected outputs while reset is held
    task automatic expReset(input string name);
        pushExp(name, -1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 0, 0);
    endtask

    // Drive a new pattern select
    task automatic applyStimulus(input logic [1:0] m);
        mode = m;
    endtask

    // Advance the stimulus to just after the posedge that registers pixel index p
    task automatic runTo(input int p);
        while (n < p) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Compare the DUT outputs against one expected entry
    task automatic checkOutput(input exp_t e);
        logic [25:0] got, want;
        got  = {Hs, Vs, Blank, frame_start, R, G, B, x, y};
        want = {e.hs, e.vs, e.blank, e.fs, e.r, e.g, e.b, e.xx, e.yy};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got hs/vs/blank/fs=%b%b%b%b rgb=%0d,%0d,%0d xy=%0d,%0d required hs/vs/blank/fs=%b%b%b%b rgb=%0d,%0d,%0d xy=%0d,%0d",
                     e.name, Hs, Vs, Blank, frame_start, R, G, B, x, y,
                     e.hs, e.vs, e.blank, e.fs, e.r, e.g, e.b, e.xx, e.yy);
        end
    endtask

    // Monitor: track the pixel index presented on the outputs and pop matching expectations
    initial begin
        int  epoch = 0;
        int  cur_p = -1;
        bit  in_rst = 1'b0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                if (!in_rst) epoch++;
                in_rst = 1'b1;
                cur_p  = -1;
            end else begin
                in_rst = 1'b0;
                cur_p++;
            end
            @(negedge clk);
            while (exp_q.size() > 0 &&
                   (exp_q[0].epoch < epoch || (exp_q[0].epoch == epoch && exp_q[0].p < cur_p))) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL %s: output never presented, required at epoch %0d index %0d",
                         exp_q[0].name, exp_q[0].epoch, exp_q[0].p);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].epoch == epoch && exp_q[0].p == cur_p) begin
                checkOutput(exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    // Stimulus: reset, walk the four patterns across frames, then reset mid-frame
    initial begin
        $display("[TB] start");
        applyStimulus(2'd0);
        expReset("reset_state");
        expActive("f0_bar0_origin", 0, 0, 0, 1'b1, 2'd3, 2'd3, 2'd3);
        expActive("f0_bar1",        0, 8, 0, 1'b0, 2'd3, 2'd3, 2'd0);
        expActive("f0_bar2",        0, 20, 0, 1'b0, 2'd3, 2'd0, 2'd3);
        expActive("f0_bar7",        0, 63, 0, 1'b0, 2'd0, 2'd0, 2'd0);
        expBlank ("f0_hblank_start",0, 64, 0, 1'b1, 1'b0);
        expBlank ("f0_hs_before",   0, 67, 0, 1'b1, 1'b0);
        expBlank ("f0_hs_first",    0, 68, 0, 1'b0, 1'b0);
        expBlank ("f0_hs_last",     0, 75, 0, 1'b0, 1'b0);
        expBlank ("f0_hs_after",    0, 76, 0, 1'b1, 1'b0);
        expActive("f0_bar4",        0, 35, 2, 1'b0, 2'd0, 2'd3, 2'd3);
        expActive("f0_bar5_aftermode", 0, 40, 8, 1'b0, 2'd0, 2'd3, 2'd0);
        expActive("f0_last_line",   0, 10, 11, 1'b0, 2'd3, 2'd3, 2'd0);
        expBlank ("f0_vblank",      0, 0, 12, 1'b1, 1'b0);
        expBlank ("f0_vs_first",    0, 0, 13, 1'b1, 1'b1);
        expBlank ("f0_vs_last_hs",  0, 79, 14, 1'b1, 1'b1);
        expBlank ("f0_vs_after",    0, 0, 15, 1'b1, 1'b0);
        expBlank ("f0_final_pixel", 0, 79, 17, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n = 0;

        runTo(6 * HTOT);
        applyStimulus(2'd3);
        expActive("f1_box_origin",  1, 0, 0, 1'b1, 2'd0, 2'd0, 2'd3);
        expActive("f1_no_fs",       1, 1, 0, 1'b0, 2'd0, 2'd0, 2'd3);
        expActive("f1_above_box",   1, 16, 3, 1'b0, 2'd0, 2'd0, 2'd3);
        expActive("f1_left_of_box", 1, 15, 4, 1'b0, 2'd0, 2'd0, 2'd3);
        expActive("f1_box_tl",      1, 16, 4, 1'b0, 2'd3, 2'd3, 2'd3);
        expActive("f1_right_of_box",1, 24, 4, 1'b0, 2'd0, 2'd0, 2'd3);
        expActive("f1_box_br",      1, 23, 11, 1'b0, 2'd3, 2'd3, 2'd3);
        expBlank ("f1_blank_rgb0",  1, 16, 12, 1'b1, 1'b0);

        runTo(FRAME + 5 * HTOT);
        applyStimulus(2'd1);
        expActive("f2_chk_origin",  2, 0, 0, 1'b1, 2'd0, 2'd0, 2'd0);
        expActive("f2_chk_x4",      2, 4, 0, 1'b0, 2'd3, 2'd3, 2'd3);
        expActive("f2_chk_y4",      2, 0, 4, 1'b0, 2'd3, 2'd3, 2'd3);
        expActive("f2_chk_x4y4",    2, 4, 4, 1'b0, 2'd0, 2'd0, 2'd0);
        expActive("f2_chk_corner",  2, 63, 11, 1'b0, 2'd3, 2'd3, 2'd3);

        runTo(2 * FRAME + 5 * HTOT);
        applyStimulus(2'd2);
        expActive("f3_ramp_0",      3, 0, 0, 1'b1, 2'd0, 2'd0, 2'd0);
        expActive("f3_ramp_4",      3, 4, 0, 1'b0, 2'd1, 2'd1, 2'd1);
        expActive("f3_ramp_8",      3, 8, 0, 1'b0, 2'd2, 2'd2, 2'd2);
        expActive("f3_ramp_12",     3, 12, 0, 1'b0, 2'd3, 2'd3, 2'd3);
        expActive("f3_ramp_wrap",   3, 16, 0, 1'b0, 2'd0, 2'd0, 2'd0);
        expActive("f3_ramp_63",     3, 63, 5, 1'b0, 2'd3, 2'd3, 2'd3);

        runTo(3 * FRAME + 5 * HTOT);
        applyStimulus(2'd3);
        expActive("f4_box_wrapped", 4, 0, 4, 1'b0, 2'd3, 2'd3, 2'd3);
        expActive("f4_box_edge",    4, 8, 4, 1'b0, 2'd0, 2'd0, 2'd3);
        expActive("f4_box_br",      4, 7, 11, 1'b0, 2'd3, 2'd3, 2'd3);
        expActive("f5_left_of_box", 5, 15, 4, 1'b0, 2'd0, 2'd0, 2'd3);
        expActive("f5_box_tl",      5, 16, 4, 1'b0, 2'd3, 2'd3, 2'd3);

        stim_epoch = 2;
        expReset("midframe_reset");
        expActive("r_origin_fs",    0, 0, 0, 1'b1, 2'd0, 2'd0, 2'd3);
        expActive("r_box_restart",  0, 0, 4, 1'b0, 2'd3, 2'd3, 2'd3);
        expActive("r_box_right",    0, 7, 4, 1'b0, 2'd3, 2'd3, 2'd3);
        expActive("r_old_box_gone", 0, 16, 4, 1'b0, 2'd0, 2'd0, 2'd3);
        runTo(5 * FRAME + 6 * HTOT + 30);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        runTo(5 * HTOT);
        repeat (2) @(negedge clk);

        while (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: never checked, required at epoch %0d index %0d",
                     exp_q[0].name, exp_q[0].epoch, exp_q[0].p);
            void'(exp_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        stim_done = 1'b1;
        $finish;
    end

endmodule
